// File: rtl/uart_rx_fifo.sv
// Receive FIFO between uart_rx and the register interface: FWFT head, trigger,
// sticky overrun, error-pending and character-timeout status.
module uart_rx_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned TO_TICKS = 640
) (
  input  logic              uart_clk_i,
  input  logic              uart_rst_n_i,
  input  logic              rx_clk_en_i,
  input  logic [9:0]        rx_fifo_data_i,
  input  logic              rx_fifo_wr_en_i,
  input  logic              rd_en_i,
  input  logic              fifo_clr_i,
  input  logic              ovr_clr_i,
  input  logic [1:0]        trig_lvl_i,
  output logic [9:0]        rd_data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o,
  output logic              trig_o,
  output logic              overrun_o,
  output logic              err_pend_o,
  output logic              timeout_o
);

  localparam int unsigned TO_W = $clog2(TO_TICKS + 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   TRIG_Q   = (ADDR_W+1)'(DEPTH / 4);
  localparam logic [ADDR_W:0]   TRIG_H   = (ADDR_W+1)'(DEPTH / 2);
  localparam logic [ADDR_W:0]   TRIG_N2  = (ADDR_W+1)'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TO_TICKS);
  localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);

  logic [9:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, err_cnt, trig_thr;
  logic [TO_W-1:0]   to_cnt;
  logic              overrun;
  logic [9:0]        head;
  logic              empty, full, wr_acc, rd_acc, wr_err, rd_err;

  assign head   = mem[rd_ptr];
  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);
  assign rd_acc = rd_en_i & ~empty;
  // A read while full frees the slot the same-cycle write lands in.
  assign wr_acc = rx_fifo_wr_en_i & (~full | rd_en_i);
  assign wr_err = wr_acc & (|rx_fifo_data_i[9:8]);
  assign rd_err = rd_acc & (|head[9:8]);

  always_ff @(posedge uart_clk_i) begin
    if (wr_acc && !fifo_clr_i) mem[wr_ptr] <= rx_fifo_data_i;
  end

  always_ff @(posedge uart_clk_i or negedge uart_rst_n_i) begin
    if (!uart_rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
      to_cnt  <= '0;
      overrun <= 1'b0;
    end else if (fifo_clr_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
      to_cnt  <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
      case ({wr_err, rd_err})
        2'b10:   err_cnt <= err_cnt + CNT_ONE;
        2'b01:   err_cnt <= err_cnt - CNT_ONE;
        default: ;
      endcase
      if (rx_fifo_wr_en_i && !wr_acc) overrun <= 1'b1;
      else if (ovr_clr_i)             overrun <= 1'b0;
      if (wr_acc || rd_acc || empty)               to_cnt <= '0;
      else if (rx_clk_en_i && (to_cnt != TO_MAX))  to_cnt <= to_cnt + TO_ONE;
    end
  end

  always_comb begin
    trig_thr = CNT_ONE;
    case (trig_lvl_i)
      2'b01:   trig_thr = TRIG_Q;
      2'b10:   trig_thr = TRIG_H;
      2'b11:   trig_thr = TRIG_N2;
      default: trig_thr = CNT_ONE;
    endcase
  end

  assign rd_data_o  = empty ? '0 : head;
  assign empty_o    = empty;
  assign full_o     = full;
  assign count_o    = count;
  assign trig_o     = (count >= trig_thr);
  assign overrun_o  = overrun;
  assign err_pend_o = (err_cnt != '0);
  assign timeout_o  = (to_cnt == TO_MAX);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int TO_TICKS = 640;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tick = 1'b0;
  logic [9:0]        wdata = '0;
  logic              wr = 1'b0, rd = 1'b0, clr = 1'b0, oclr = 1'b0;
  logic [1:0]        lvl = '0;
  logic [9:0]        rd_data;
  logic              empty, full, trig, ovr, err_pend, timeout;
  logic [ADDR_W:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] q[$];
  bit         m_ovr = 0;
  int         m_idle = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TO_TICKS(TO_TICKS)) dut (
    .uart_clk_i      (clk),
    .uart_rst_n_i    (rst_n),
    .rx_clk_en_i     (tick),
    .rx_fifo_data_i  (wdata),
    .rx_fifo_wr_en_i (wr),
    .rd_en_i         (rd),
    .fifo_clr_i      (clr),
    .ovr_clr_i       (oclr),
    .trig_lvl_i      (lvl),
    .rd_data_o       (rd_data),
    .empty_o         (empty),
    .full_o          (full),
    .count_o         (count),
    .trig_o          (trig),
    .overrun_o       (ovr),
    .err_pend_o      (err_pend),
    .timeout_o       (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_errs();
    int n = 0;
    foreach (q[i]) if (q[i][9:8] != 2'b00) n++;
    return n;
  endfunction

  function automatic int trig_level(input logic [1:0] l);
    case (l)
      2'd0:    return 1;
      2'd1:    return DEPTH / 4;
      2'd2:    return DEPTH / 2;
      default: return DEPTH - 2;
    endcase
  endfunction

  task automatic check_all(input string tag);
    int sz = q.size();
    chk({tag, ".count"},    32'(count),    32'(sz));
    chk({tag, ".empty"},    32'(empty),    32'(sz == 0));
    chk({tag, ".full"},     32'(full),     32'(sz == DEPTH));
    chk({tag, ".rd_data"},  32'(rd_data),  (sz == 0) ? 32'h0 : 32'(q[0]));
    chk({tag, ".trig"},     32'(trig),     32'(sz >= trig_level(lvl)));
    chk({tag, ".overrun"},  32'(ovr),      32'(m_ovr));
    chk({tag, ".err_pend"}, 32'(err_pend), 32'(model_errs() != 0));
    chk({tag, ".timeout"},  32'(timeout),  32'(m_idle >= TO_TICKS));
  endtask

  task automatic model_step(input bit w, input logic [9:0] d, input bit r,
                            input bit c, input bit oc, input bit t);
    int sz = q.size();
    bit ra, wa;
    if (c) begin
      q.delete();
      m_ovr  = 0;
      m_idle = 0;
    end else begin
      ra = r && (sz > 0);
      wa = w && ((sz < DEPTH) || r);
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(d);
      if (w && !wa)   m_ovr = 1;
      else if (oc)    m_ovr = 0;
      if (ra || wa || sz == 0)            m_idle = 0;
      else if (t && m_idle < TO_TICKS)    m_idle++;
    end
  endtask

  // Called at posedge+1; applies one cycle of inputs and checks afterwards.
  task automatic cycle(input string tag, input bit w, input logic [9:0] d, input bit r,
                       input bit c, input bit oc, input bit t, input logic [1:0] l);
    wr = w; wdata = d; rd = r; clr = c; oclr = oc; tick = t; lvl = l;
    model_step(w, d, r, c, oc, t);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit         wr;
    logic [9:0] d;
    bit         rd;
    logic [1:0] lvl;
    int         cnt;
    logic [9:0] dat;
    bit         trig;
    bit         err;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1, 10'h023, 0, 2'd0, 1, 10'h023, 1, 0};
    vecs[1]  = '{0, 10'h000, 1, 2'd0, 0, 10'h000, 0, 0};
    vecs[2]  = '{1, 10'h2A5, 0, 2'd1, 1, 10'h2A5, 0, 1};
    vecs[3]  = '{1, 10'h011, 0, 2'd1, 2, 10'h2A5, 0, 1};
    vecs[4]  = '{0, 10'h000, 1, 2'd1, 1, 10'h011, 0, 0};
    vecs[5]  = '{1, 10'h001, 0, 2'd1, 2, 10'h011, 0, 0};
    vecs[6]  = '{1, 10'h002, 0, 2'd1, 3, 10'h011, 0, 0};
    vecs[7]  = '{1, 10'h003, 0, 2'd1, 4, 10'h011, 1, 0};
    vecs[8]  = '{0, 10'h000, 0, 2'd2, 4, 10'h011, 0, 0};
    vecs[9]  = '{0, 10'h000, 0, 2'd3, 4, 10'h011, 0, 0};
    vecs[10] = '{0, 10'h000, 1, 2'd0, 3, 10'h001, 1, 0};
    vecs[11] = '{0, 10'h000, 1, 2'd0, 2, 10'h002, 1, 0};
    vecs[12] = '{0, 10'h000, 1, 2'd0, 1, 10'h003, 1, 0};
    vecs[13] = '{0, 10'h000, 1, 2'd0, 0, 10'h000, 0, 0};

    // Reset values
    #22;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      cycle("tbl", vecs[i].wr, vecs[i].d, vecs[i].rd, 0, 0, 0, vecs[i].lvl);
      chk($sformatf("tbl%0d.count", i),    32'(count),    32'(vecs[i].cnt));
      chk($sformatf("tbl%0d.rd_data", i),  32'(rd_data),  32'(vecs[i].dat));
      chk($sformatf("tbl%0d.trig", i),     32'(trig),     32'(vecs[i].trig));
      chk($sformatf("tbl%0d.err_pend", i), 32'(err_pend), 32'(vecs[i].err));
    end

    // Fill, overrun, drain in order
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1, 10'(i), 0, 0, 0, 0, 2'd0);
    cycle("ovr_wr", 1, 10'h055, 0, 0, 0, 0, 2'd0);
    chk("ovr.full", 32'(full), 32'd1);
    chk("ovr.overrun", 32'(ovr), 32'd1);
    chk("ovr.count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.head", 32'(rd_data), 32'(i));
      cycle("drain", 0, '0, 1, 0, 0, 0, 2'd0);
    end
    chk("drain.empty", 32'(empty), 32'd1);
    chk("drain.ovr_kept", 32'(ovr), 32'd1);
    cycle("ovr_clr", 0, '0, 0, 0, 1, 0, 2'd0);
    chk("ovr_clr.overrun", 32'(ovr), 32'd0);

    // Overrun set beats same-cycle clear
    for (int i = 0; i < DEPTH; i++) cycle("fill2", 1, 10'(8'h80 + i), 0, 0, 0, 0, 2'd0);
    cycle("ovr_setclr", 1, 10'h0AA, 0, 0, 1, 0, 2'd0);
    chk("setclr.overrun", 32'(ovr), 32'd1);
    cycle("ovr_clr2", 0, '0, 0, 0, 1, 0, 2'd0);

    // Read+write while full
    cycle("full_rw", 1, 10'h03C, 1, 0, 0, 0, 2'd0);
    chk("full_rw.count", 32'(count), 32'(DEPTH));
    chk("full_rw.overrun", 32'(ovr), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) cycle("drain2", 0, '0, 1, 0, 0, 0, 2'd0);
    chk("full_rw.last", 32'(rd_data), 32'h03C);
    cycle("drain2_last", 0, '0, 1, 0, 0, 0, 2'd0);
    cycle("empty_rw", 1, 10'h177, 1, 0, 0, 0, 2'd0);
    chk("empty_rw.count", 32'(count), 32'd1);
    chk("empty_rw.data", 32'(rd_data), 32'h177);
    cycle("empty_rw_rd", 0, '0, 1, 0, 0, 0, 2'd0);

    // Character timeout
    cycle("to_wr", 1, 10'h042, 0, 0, 0, 0, 2'd0);
    for (int i = 0; i < TO_TICKS; i++) begin
      if ($urandom_range(3) == 0) cycle("to_gap", 0, '0, 0, 0, 0, 0, 2'd0);
      cycle("to_tick", 0, '0, 0, 0, 0, 1, 2'd0);
      if (i == TO_TICKS - 2) chk("to.before", 32'(timeout), 32'd0);
    end
    chk("to.after", 32'(timeout), 32'd1);
    cycle("to_sat", 0, '0, 0, 0, 0, 1, 2'd0);
    chk("to.sat", 32'(timeout), 32'd1);
    cycle("to_rd", 0, '0, 1, 0, 0, 0, 2'd0);
    chk("to_rd.timeout", 32'(timeout), 32'd0);
    chk("to_rd.empty", 32'(empty), 32'd1);

    // Flush beats a same-cycle write
    for (int i = 0; i < 5; i++) cycle("pre_clr", 1, 10'(10'h300 + i), 0, 0, 0, 1, 2'd0);
    cycle("clr_wr", 1, 10'h0FF, 1, 1, 0, 1, 2'd0);
    chk("clr.count", 32'(count), 32'd0);
    chk("clr.empty", 32'(empty), 32'd1);
    chk("clr.err_pend", 32'(err_pend), 32'd0);

    // Randomized traffic in phases biased toward fill or drain
    for (int p = 0; p < 6; p++) begin
      int wr_pct = (p % 2 == 0) ? 75 : 30;
      for (int i = 0; i < 250; i++) begin
        bit w  = ($urandom_range(99) < wr_pct);
        bit r  = ($urandom_range(99) < 100 - wr_pct);
        bit c  = ($urandom_range(199) == 0);
        bit oc = ($urandom_range(19) == 0);
        bit t  = ($urandom_range(1) == 0);
        cycle("rand", w, 10'($urandom), r, c, oc, t, 2'($urandom));
      end
    end

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1, 10'(10'h200 + i), 0, 0, 0, 0, 2'd0);
    cycle("pre_rst_ovr", 0, '0, 0, 0, 0, 0, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_ovr  = 0;
    m_idle = 0;
    check_all("async_rst");
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("post_rst", 1, 10'h123, 0, 0, 0, 0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of uart_rx.
- Captures each 10-bit word uart_rx presents on its rx_fifo_data/rx_fifo_wr_en outputs and holds it for the register/CPU side.
- Presents the head entry first-word-fall-through, with fill-level trigger, sticky overrun, error-pending and character-timeout status for the interrupt logic.
- Timeout is timed in 16x-oversample ticks taken from baud_rate_gen's RX clock enable.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4
ADDR_W, 4, log2(DEPTH)
TO_TICKS, 640, rx_clk_en ticks of idle before timeout (4 chars x 10 bits x 16)

Ports:
uart_clk_i  input  1  system clock, rising edge
uart_rst_n_i  input  1  asynchronous active-low reset
rx_clk_en_i  input  1  16x baud tick from baud_rate_gen
rx_fifo_data_i  input  10  uart_rx word: [7:0] data, [8] parity error, [9] framing error
rx_fifo_wr_en_i  input  1  one-cycle write strobe from uart_rx
rd_en_i  input  1  pop head entry
fifo_clr_i  input  1  synchronous flush
ovr_clr_i  input  1  clear sticky overrun
trig_lvl_i  input  2  trigger select
rd_data_o  output  10  head entry, FWFT
empty_o  output  1  no entries
full_o  output  1  DEPTH entries
count_o  output  ADDR_W+1  entries held, 0..DEPTH
trig_o  output  1  count_o >= trigger level
overrun_o  output  1  sticky: write dropped while full
err_pend_o  output  1  at least one stored entry has bit 8 or 9 set
timeout_o  output  1  non-empty and idle for TO_TICKS ticks

Behaviour:
Reset (async, uart_rst_n_i=0):
- Pointers, count, error count and timeout counter = 0.
- rd_data_o=0, empty_o=1, full_o=0, count_o=0, trig_o=0, overrun_o=0, err_pend_o=0, timeout_o=0.
- Memory contents don't care.

Storage:
- Circular buffer of DEPTH x 10 with wr_ptr/rd_ptr of ADDR_W bits; both wrap DEPTH-1 -> 0.
- count_o is a registered counter.
- empty_o = (count_o==0); full_o = (count_o==DEPTH).

Write accepted = rx_fifo_wr_en_i & (!full_o | rd_en_i).
- Stores the word at wr_ptr; the entry is visible on rd_data_o the next cycle if the FIFO was empty.

Read accepted = rd_en_i & !empty_o.
- Advances rd_ptr. rd_data_o = mem[rd_ptr] when non-empty, else 10'h0.
- rd_en_i while empty: ignored, no state change.

Simultaneous read and write:
- Both accepted, count unchanged. This includes the full case: a read and write in the same cycle while full are both accepted.
- When empty, only the write takes effect.

Overrun:
- rx_fifo_wr_en_i while full and no read accepted: word dropped, overrun_o <= 1.
- ovr_clr_i clears overrun_o. If set and clear occur in the same cycle, set wins.

Error tracking:
- err_cnt (ADDR_W+1 bits): +1 on an accepted write with data[9:8]!=0; -1 on an accepted read whose head has [9:8]!=0. Net 0 if both happen in the same cycle.
- err_pend_o = (err_cnt != 0).

Trigger levels (trig_lvl_i):
- 00 -> 1, 01 -> DEPTH/4, 10 -> DEPTH/2, 11 -> DEPTH-2.
- trig_o is combinational from count_o and trig_lvl_i.

Timeout:
- to_cnt increments on each rx_clk_en_i while non-empty and saturates at TO_TICKS.
- Reset to 0 on any accepted read, any accepted write, or empty.
- timeout_o = (to_cnt == TO_TICKS), so it drops the cycle after a read or write.

fifo_clr_i:
- Highest priority. Next cycle: pointers, count, err_cnt, to_cnt and overrun_o = 0.
- Any same-cycle write or read is discarded.

Other rules:
- No combinational path from rd_en_i to any output except through registers.
- Mid-operation async reset returns every output to its reset value immediately.

Test Plan:
- Reset, then write 8'h23 with no errors -> next cycle empty_o=0, count_o=1, rd_data_o=10'h023, err_pend_o=0. rd_en_i one cycle -> empty_o=1, rd_data_o=10'h000.
- Write 16 words 0x00..0x0F, then a 17th (0x55) -> full_o=1, overrun_o=1, count_o=16. Read all 16 -> 0x00..0x0F in order, 0x55 never appears. ovr_clr_i -> overrun_o=0.
- trig_lvl_i=01, write 3 words -> trig_o=0; 4th write -> trig_o=1. Switch to trig_lvl_i=10 -> trig_o=0. trig_lvl_i=00 with 1 entry -> trig_o=1.
- Write 10'h2A5 (framing error) then 10'h011 -> err_pend_o=1. First read -> err_pend_o=0, rd_data_o=10'h011.
- FIFO full, rd_en_i and rx_fifo_wr_en_i (0x3C) in the same cycle -> count_o stays 16, overrun_o=0, 0x3C read last. Empty FIFO with read+write -> count_o=1.
- TO_TICKS=640, 1 entry, 640 rx_clk_en_i pulses -> timeout_o=1 exactly after the 640th tick. Single read -> timeout_o=0, empty_o=1. Then fill 5 entries and assert fifo_clr_i together with a write -> count_o=0, empty_o=1.
